// File: rtl/trace_packer.sv
// trace_packer: capture front-end of the trace buffer.
// Packs 2**k parallel trace bits per cycle, LSB-first, into TRB_WIDTH-bit
// words for the trace logger. It records the one-hot bit position of the
// first trigger. In streaming mode it unpacks words returned by the logger
// back onto a parallel stream output.
//
// Handshake: LOAD_O and STORE_I are single-cycle strobes with no backpressure.
// DATA_O is meaningful in the cycle where LOAD_O=1, and it holds until the
// next completion. DATA_I is sampled in the cycle where STORE_I=1 (MODE_I=1
// only). The logger must accept every LOAD_O, because packing never stalls.
//
// Optional feature: define TRACE_PACKER_FLUSH_EN to add FLUSH_I. A flush
// zero-pads and emits a partially filled word.
module trace_packer #(
  parameter int TRB_WIDTH      = 32,
  parameter int TRB_MAX_TRACES = 8
) (
  input  logic                              CLK_I,
  input  logic                              RST_NI,
  input  logic                              ENABLE_I,
  input  logic                              MODE_I,
  input  logic [$clog2(TRB_MAX_TRACES)-1:0] NTRACE_I,
  input  logic [TRB_MAX_TRACES-1:0]         TRACE_I,
  input  logic                              TRG_I,
`ifdef TRACE_PACKER_FLUSH_EN
  input  logic                              FLUSH_I,
`endif
  output logic [TRB_WIDTH-1:0]              DATA_O,
  output logic                              LOAD_O,
  output logic [TRB_WIDTH-1:0]              EVENT_POS_O,
  output logic                              TRG_EVENT_O,
  input  logic [TRB_WIDTH-1:0]              DATA_I,
  input  logic                              STORE_I,
  output logic [TRB_MAX_TRACES-1:0]         STREAM_O,
  output logic                              STREAM_VALID_O,
  output logic                              OVERRUN_O
);

  localparam int KW = $clog2(TRB_MAX_TRACES);
  localparam int CW = $clog2(TRB_WIDTH) + 1;
  localparam logic [KW-1:0] K_MAX = KW'(KW);
  localparam logic [TRB_WIDTH-1:0] ONE_W = {{(TRB_WIDTH-1){1'b0}}, 1'b1};

  // pack-path state
  logic [TRB_WIDTH-1:0] r_asm;
  logic [CW-1:0]        r_cnt;
  logic [KW-1:0]        r_k;
  logic [TRB_WIDTH-1:0] r_data;
  logic                 r_load;
  // trigger state
  logic                 r_trg_event;
  logic                 r_pend;
  logic [TRB_WIDTH-1:0] r_pend_pos;
  logic [TRB_WIDTH-1:0] r_event_pos;
  // unpack-path state
  logic [TRB_WIDTH-1:0] r_ubuf;
  logic [CW-1:0]        r_ucnt;
  logic [KW-1:0]        r_uk;
  logic                 r_overrun;

  logic [KW-1:0]        w_k_in;
  logic [KW-1:0]        w_k;
  logic [CW-1:0]        w_n;
  logic [CW-1:0]        w_cnt_sum;
  logic                 w_natural;
  logic                 w_flush;
  logic                 w_done;
  logic                 w_capture;
  logic [TRB_WIDTH-1:0] w_cnt_onehot;
  logic [TRB_WIDTH-1:0] w_pos;
  logic                 w_has_pos;
  logic [TRB_WIDTH-1:0] w_asm_next;
  logic [TRB_WIDTH-1:0] w_word;
  logic [CW-1:0]        w_un;
  logic                 w_store;
  logic                 w_svalid;
  logic [TRB_MAX_TRACES-1:0] w_stream;

  // The requested exponent is clamped. A new k is only honoured at a word
  // boundary (cnt==0); mid-word, the latched value keeps the word consistent.
  assign w_k_in       = (NTRACE_I > K_MAX) ? K_MAX : NTRACE_I;
  assign w_k          = (r_cnt == '0) ? w_k_in : r_k;
  assign w_n          = CW'(1) << w_k;
  assign w_cnt_sum    = r_cnt + w_n;
  assign w_natural    = ENABLE_I && (w_cnt_sum == CW'(TRB_WIDTH));
  assign w_capture    = ENABLE_I && TRG_I && !r_trg_event;
  assign w_cnt_onehot = ONE_W << r_cnt;
  // A trigger captured in the completing cycle is reported with that word.
  assign w_pos        = w_capture ? w_cnt_onehot : r_pend_pos;
  assign w_has_pos    = w_capture || r_pend;
  assign w_done       = w_natural || w_flush;

  // Insert this cycle's samples at bit offset cnt of the assembly register.
  always_comb begin
    w_asm_next = r_asm;
    for (int j = 0; j < TRB_WIDTH; j++) begin
      if (ENABLE_I && (CW'(j) >= r_cnt) && (CW'(j) < w_cnt_sum)) begin
        w_asm_next[j] = TRACE_I[KW'(CW'(j) - r_cnt)];
      end
    end
  end

`ifdef TRACE_PACKER_FLUSH_EN
  logic [CW-1:0] w_fill;
  assign w_flush = FLUSH_I && (r_cnt != '0);
  assign w_fill  = ENABLE_I ? w_cnt_sum : r_cnt;

  // Zero-pad every bit above the fill level, so a flushed word is clean.
  always_comb begin
    w_word = '0;
    for (int j = 0; j < TRB_WIDTH; j++) begin
      if (CW'(j) < w_fill) begin
        w_word[j] = w_asm_next[j];
      end
    end
  end
`else
  assign w_flush = 1'b0;
  assign w_word  = w_asm_next;
`endif

  // Pack path: assemble, complete words into the output register, track trigger.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_asm       <= '0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_data      <= '0;
      r_load      <= 1'b0;
      r_trg_event <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_pos  <= '0;
      r_event_pos <= '0;
    end else begin
      r_load <= 1'b0;
      r_asm  <= w_asm_next;
      if (r_cnt == '0) begin
        r_k <= w_k_in;
      end
      if (w_done) begin
        r_data <= w_word;
        r_load <= 1'b1;
        r_cnt  <= '0;
        if (w_has_pos) begin
          r_event_pos <= w_pos;
          r_pend      <= 1'b0;
        end
      end else if (ENABLE_I) begin
        r_cnt <= w_cnt_sum;
      end
      if (w_capture) begin
        r_trg_event <= 1'b1;
        if (!w_done) begin
          r_pend     <= 1'b1;
          r_pend_pos <= w_cnt_onehot;
        end
      end
    end
  end

  assign w_un    = CW'(1) << r_uk;
  assign w_store = MODE_I && STORE_I;

  // Unpack path: load on store, then emit one n-bit beat per cycle.
  // A store during the final beat replaces nothing unsent, so it is not an overrun.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_ubuf    <= '0;
      r_ucnt    <= '0;
      r_uk      <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_store) begin
        r_ubuf <= DATA_I;
        r_ucnt <= CW'(TRB_WIDTH) >> r_k;
        r_uk   <= r_k;
        if (r_ucnt > CW'(1)) begin
          r_overrun <= 1'b1;
        end
      end else if (r_ucnt != '0) begin
        r_ubuf <= r_ubuf >> w_un;
        r_ucnt <= r_ucnt - CW'(1);
      end
    end
  end

  assign w_svalid = (r_ucnt != '0);

  // The stream beat is the low n bits of the shift buffer; unused lanes are zero.
  always_comb begin
    w_stream = '0;
    for (int i = 0; i < TRB_MAX_TRACES; i++) begin
      if (w_svalid && (CW'(i) < w_un)) begin
        w_stream[i] = r_ubuf[i];
      end
    end
  end

  assign DATA_O         = r_data;
  assign LOAD_O         = r_load;
  assign EVENT_POS_O    = r_event_pos;
  assign TRG_EVENT_O    = r_trg_event;
  assign STREAM_O       = w_stream;
  assign STREAM_VALID_O = w_svalid;
  assign OVERRUN_O      = r_overrun;

endmodule

// File: tb/tb_trace_packer.sv
// Testbench for trace_packer. The reference model is a bit queue: samples
// are appended LSB-first, and 32 queued bits form one word. Stream beats are
// a queue of expected n-bit slices of each stored word.
module tb_trace_packer;
  localparam int W  = 32;
  localparam int M  = 8;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          mode = 1'b0;
  logic [KW-1:0] ntrace = '0;
  logic [M-1:0]  trace = '0;
  logic          trg = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          store = 1'b0;
  logic [W-1:0]  data_o;
  logic          load_o;
  logic [W-1:0]  event_pos_o;
  logic          trg_event_o;
  logic [M-1:0]  stream_o;
  logic          stream_valid_o;
  logic          overrun_o;
`ifdef TRACE_PACKER_FLUSH_EN
  logic          flush = 1'b0;
`endif

  trace_packer #(.TRB_WIDTH(W), .TRB_MAX_TRACES(M)) dut (
    .CLK_I(clk), .RST_NI(rst_n), .ENABLE_I(en), .MODE_I(mode),
    .NTRACE_I(ntrace), .TRACE_I(trace), .TRG_I(trg),
`ifdef TRACE_PACKER_FLUSH_EN
    .FLUSH_I(flush),
`endif
    .DATA_O(data_o), .LOAD_O(load_o), .EVENT_POS_O(event_pos_o),
    .TRG_EVENT_O(trg_event_o), .DATA_I(data_i), .STORE_I(store),
    .STREAM_O(stream_o), .STREAM_VALID_O(stream_valid_o), .OVERRUN_O(overrun_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  // reference model state
  bit           m_bits[$];
  int           m_n;
  int           m_klat;
  logic [W-1:0] m_data;
  logic [W-1:0] m_evpos;
  bit           m_load;
  bit           m_trg;
  bit           m_pend;
  int           m_pos;
  bit           m_ovr;
  logic [M-1:0] exp_q[$];
  bit           m_sv;
  logic [M-1:0] m_so;

  function automatic int clampk(input int k);
    return (k > 3) ? 3 : k;
  endfunction

  task automatic model_clear();
    m_bits.delete();
    exp_q.delete();
    m_n = 1; m_klat = 0; m_data = '0; m_evpos = '0; m_load = 0;
    m_trg = 0; m_pend = 0; m_pos = 0; m_ovr = 0; m_sv = 0; m_so = '0;
  endtask

  // driver: apply one cycle of inputs, advance the model past the edge,
  // and return 1 ns after the edge.
  task automatic cycle(input bit e, input bit md, input int k, input logic [M-1:0] t,
                       input bit g, input bit st, input logic [W-1:0] d);
    bit           was_empty;
    int           un;
    logic [W-1:0] sh;
    en = e; mode = md; ntrace = KW'(k); trace = t; trg = g; store = st; data_i = d;
    @(posedge clk);
    was_empty = (m_bits.size() == 0);
    m_load = 0;
    if (st && md) begin
      m_ovr = m_ovr | (exp_q.size() != 0);
      exp_q.delete();
      un = 1 << m_klat;
      for (int b = 0; b < W / un; b++) begin
        sh = d >> (b * un);
        exp_q.push_back(M'(sh) & M'((1 << un) - 1));
      end
    end
    if (e) begin
      if (was_empty) m_n = 1 << clampk(k);
      if (g && !m_trg) begin
        m_trg = 1; m_pend = 1; m_pos = m_bits.size();
      end
      for (int i = 0; i < m_n; i++) m_bits.push_back(t[i]);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) m_data[i] = m_bits[i];
        m_bits.delete();
        m_load = 1;
        if (m_pend) begin
          m_evpos = '0; m_evpos[m_pos] = 1'b1; m_pend = 0;
        end
      end
    end
    if (was_empty) m_klat = clampk(k);
    m_sv = (exp_q.size() != 0);
    m_so = m_sv ? exp_q.pop_front() : '0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 0; mode = 0; ntrace = '0; trace = '0; trg = 0; store = 0; data_i = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [W-1:0] outs [7];
    string        names [7];
    // reset values with RST_NI still low from time 0
    #3;
    outs = '{data_o, W'(load_o), event_pos_o, W'(trg_event_o), W'(stream_o),
             W'(stream_valid_o), W'(overrun_o)};
    names = '{"rst_data", "rst_load", "rst_evpos", "rst_trgev", "rst_stream", "rst_svalid", "rst_ovr"};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (outs[i] !== '0) begin
        failures++; $display("FAIL %s got=%h exp=0", names[i], outs[i]);
      end
    end
    do_reset();
    // drive activity, then assert reset asynchronously mid-cycle
    cycle(0, 1, 1, '0, 0, 0, '0);
    cycle(0, 1, 1, '0, 0, 1, $urandom);
    for (int i = 0; i < 40; i++) cycle(1, 1, 3, M'($urandom), (i == 5), (i == 2), $urandom);
    #2 rst_n = 1'b0;
    #1;
    outs = '{data_o, W'(load_o), event_pos_o, W'(trg_event_o), W'(stream_o),
             W'(stream_valid_o), W'(overrun_o)};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (outs[i] !== '0) begin
        failures++; $display("FAIL async_%s got=%h exp=0", names[i], outs[i]);
      end
    end
  endtask

  task automatic test_single_trace();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      cycle(1, 0, 0, {7'($urandom), (i % 2 == 0)}, 0, 0, '0);
      checks++;
      if (load_o !== ((i == 31) || (i == 63))) begin
        failures++; $display("FAIL single_load i=%0d got=%0b exp=%0b", i, load_o, (i == 31) || (i == 63));
      end
      if (i == 31 || i == 63) begin
        checks++;
        if (data_o !== 32'h5555_5555) begin
          failures++; $display("FAIL single_data got=%h exp=55555555", data_o);
        end
      end
    end
  endtask

  task automatic test_byte_pack();
    logic [M-1:0] bytes [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 3, bytes[i], 0, 0, '0);
      checks++;
      if (load_o !== (i == 3)) begin
        failures++; $display("FAIL byte_load i=%0d got=%0b exp=%0b", i, load_o, i == 3);
      end
    end
    checks++;
    if (data_o !== 32'hA3A2_A1A0) begin
      failures++; $display("FAIL byte_data got=%h exp=a3a2a1a0", data_o);
    end
  endtask

  task automatic test_trigger();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 3, M'($urandom), (i == 2) || (i == 5), 0, '0);
      checks++;
      if (trg_event_o !== (i >= 2)) begin
        failures++; $display("FAIL trg_sticky i=%0d got=%0b exp=%0b", i, trg_event_o, i >= 2);
      end
      checks++;
      if (event_pos_o !== ((i >= 3) ? 32'h0001_0000 : 32'h0)) begin
        failures++; $display("FAIL trg_pos i=%0d got=%h exp=%h", i, event_pos_o, (i >= 3) ? 32'h0001_0000 : 32'h0);
      end
      if (i == 3 || i == 7) begin
        checks++;
        if (load_o !== 1'b1 || data_o !== m_data) begin
          failures++; $display("FAIL trg_word i=%0d got=%b/%h exp=1/%h", i, load_o, data_o, m_data);
        end
      end
    end
  endtask

  task automatic test_ntrace_change();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1, 0, (i < 3) ? 2 : 3, M'($urandom), 0, 0, '0);
      checks++;
      if (load_o !== ((i == 7) || (i == 11))) begin
        failures++; $display("FAIL kchg_load i=%0d got=%0b exp=%0b", i, load_o, (i == 7) || (i == 11));
      end
      if (load_o) begin
        checks++;
        if (data_o !== m_data) begin
          failures++; $display("FAIL kchg_data i=%0d got=%h exp=%h", i, data_o, m_data);
        end
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    cycle(0, 1, 2, '0, 0, 0, '0);
    cycle(0, 1, 2, '0, 0, 0, '0);
    // 30 cycles: word 0x87654321, idle gap, word2, word3 at word2's last beat,
    // word4 at word3's 4th beat, then drain
    for (int c = 0; c < 30; c++) begin
      bit st;
      st = (c == 0) || (c == 9) || (c == 17) || (c == 21);
      cycle(0, 1, 2, '0, 0, st, (c == 0) ? 32'h8765_4321 : W'($urandom));
      if (c < 8) begin
        checks++;
        if (stream_valid_o !== 1'b1 || stream_o !== M'(c + 1)) begin
          failures++; $display("FAIL stream_beat c=%0d got=%b/%h exp=1/%h", c, stream_valid_o, stream_o, M'(c + 1));
        end
      end
      checks++;
      if (stream_valid_o !== m_sv || stream_o !== m_so) begin
        failures++; $display("FAIL stream_model c=%0d got=%b/%h exp=%b/%h", c, stream_valid_o, stream_o, m_sv, m_so);
      end
      checks++;
      if (overrun_o !== (c >= 21)) begin
        failures++; $display("FAIL overrun c=%0d got=%0b exp=%0b", c, overrun_o, c >= 21);
      end
    end
  endtask

  task automatic test_reset_midword();
    int loads;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, M'($urandom), 0, 0, '0);
    #2 rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    loads = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1, 0, 0, M'($urandom), 0, 0, '0);
      if (load_o) loads++;
      checks++;
      if (load_o !== (i == 31)) begin
        failures++; $display("FAIL rstmid_load i=%0d got=%0b exp=%0b", i, load_o, i == 31);
      end
    end
    checks++;
    if (loads != 1 || data_o !== m_data) begin
      failures++; $display("FAIL rstmid_word got=%0d/%h exp=1/%h", loads, data_o, m_data);
    end
  endtask

  task automatic test_random();
    int k;
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      k = $urandom_range(0, 7);
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 15) == 0) k = $urandom_range(0, 7);
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), k, M'($urandom),
              $urandom_range(0, 40) == 0, $urandom_range(0, 12) == 0, W'($urandom));
        checks++;
        if (load_o !== m_load) begin
          failures++; $display("FAIL rnd_load c=%0d got=%0b exp=%0b", c, load_o, m_load);
        end
        checks++;
        if (data_o !== m_data) begin
          failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, data_o, m_data);
        end
        checks++;
        if (event_pos_o !== m_evpos || trg_event_o !== m_trg) begin
          failures++; $display("FAIL rnd_trg c=%0d got=%h/%b exp=%h/%b", c, event_pos_o, trg_event_o, m_evpos, m_trg);
        end
        checks++;
        if (stream_valid_o !== m_sv || stream_o !== m_so) begin
          failures++; $display("FAIL rnd_stream c=%0d got=%b/%h exp=%b/%h", c, stream_valid_o, stream_o, m_sv, m_so);
        end
        checks++;
        if (overrun_o !== m_ovr) begin
          failures++; $display("FAIL rnd_ovr c=%0d got=%0b exp=%0b", c, overrun_o, m_ovr);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_trace();
    test_byte_pack();
    test_trigger();
    test_ntrace_change();
    test_stream();
    test_reset_midword();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
